// File: rtl/debounce_sync.sv
// debounce_sync: input conditioning ahead of the edge detector.
// A raw asynchronous level is brought into the clk domain through a
// SYNC_STAGES-deep flop chain. A two-state counter FSM then forwards a new
// level to d_o only after STABLE_CYCLES consecutive synchronized samples
// agree on it. Candidate transitions that collapse before qualifying are
// tallied in a saturating glitch counter for diagnostics.
module debounce_sync #(
    parameter int   SYNC_STAGES   = 2,
    parameter int   STABLE_CYCLES = 8,
    parameter logic RESET_VAL     = 1'b0,
    parameter int   CNT_W         = $clog2(STABLE_CYCLES + 1)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       raw_i,
    input  logic       clr_i,
    output logic       d_o,
    output logic       busy_o,
    output logic [7:0] glitch_cnt_o
);

    typedef enum logic {
        STABLE = 1'b0,
        CHECK  = 1'b1
    } state_t;

    // Counter value on the cycle before the qualifying sample lands.
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [7:0]       GLITCH_MAX = 8'hFF;

    // Saturating increment: the diagnostic count pins at 255, never wraps.
    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == GLITCH_MAX) ? v : v + 8'd1;
    endfunction

    // Stage 1 may go metastable; only stage 2 ever reads it, and the FSM
    // only reads the final stage.
    logic [SYNC_STAGES-1:0] sync_p0;
    logic                   s;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             d_nxt;
    logic             glitch_evt;

    // ---- synchronizer stage ----
    // Shift raw_i through the synchronizer chain.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_p0 <= {SYNC_STAGES{RESET_VAL}};
        end else begin
            sync_p0 <= {sync_p0[SYNC_STAGES-2:0], raw_i};
        end
    end

    assign s = sync_p0[SYNC_STAGES-1];

    // ---- debounce FSM ----
    // State, stability counter and debounced output register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= STABLE;
            cnt   <= '0;
            d_o   <= RESET_VAL;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            d_o   <= d_nxt;
        end
    end

    // Next-state logic: qualify a differing level or reject it as a glitch.
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        d_nxt      = d_o;
        glitch_evt = 1'b0;
        case (state)
            STABLE: begin
                if (s != d_o) begin
                    state_nxt = CHECK;
                    cnt_nxt   = CNT_ONE;
                end else begin
                    cnt_nxt   = '0;
                end
            end
            CHECK: begin
                if (s == d_o) begin
                    // Level fell back before qualifying.
                    state_nxt  = STABLE;
                    cnt_nxt    = '0;
                    glitch_evt = 1'b1;
                end else if (cnt == CNT_LAST) begin
                    // This sample completes the stable run; commit it.
                    d_nxt     = s;
                    state_nxt = STABLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt   = cnt + CNT_ONE;
                end
            end
            default: begin
                state_nxt = STABLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Busy is a pure decode of the state register, so no path from raw_i.
    assign busy_o = (state == CHECK);

    // ---- diagnostics ----
    // Saturating glitch tally; a clear on the same edge takes priority.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            glitch_cnt_o <= '0;
        end else if (clr_i) begin
            glitch_cnt_o <= '0;
        end else if (glitch_evt) begin
            glitch_cnt_o <= sat_inc(glitch_cnt_o);
        end
    end

endmodule

// File: tb/tb_debounce_sync.sv
// Scoreboard bench for debounce_sync. The driver applies one input vector per
// clock and pushes the outputs a run-length reference model predicts for the
// following edge; a monitor pops and compares after every rising edge.
module tb_debounce_sync;

    localparam int   SYNC_STAGES   = 2;
    localparam int   STABLE_CYCLES = 8;
    localparam logic RESET_VAL     = 1'b0;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       raw_i = 1'b0;
    logic       clr_i = 1'b0;
    logic       d_o;
    logic       busy_o;
    logic [7:0] glitch_cnt_o;

    debounce_sync #(
        .SYNC_STAGES  (SYNC_STAGES),
        .STABLE_CYCLES(STABLE_CYCLES),
        .RESET_VAL    (RESET_VAL)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .raw_i       (raw_i),
        .clr_i       (clr_i),
        .d_o         (d_o),
        .busy_o      (busy_o),
        .glitch_cnt_o(glitch_cnt_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       d;
        logic       busy;
        logic [7:0] gcnt;
    } exp_t;

    exp_t  exp_q[$];
    int    n_vec  = 0;
    int    n_fail = 0;
    string phase  = "init";

    // Reference model: the synchronizer is a pure delay line of raw samples;
    // the debouncer tracks how many consecutive delayed samples differ from
    // the current output level.
    logic m_line[$];
    logic m_d;
    int   m_run;
    int   m_gl;

    function automatic void model_reset();
        m_line = {};
        for (int i = 0; i < SYNC_STAGES; i++) m_line.push_back(RESET_VAL);
        m_d   = RESET_VAL;
        m_run = 0;
        m_gl  = 0;
    endfunction

    function automatic void model_edge(input logic raw, input logic clr);
        logic s;
        s = m_line.pop_front();
        m_line.push_back(raw);
        if (s != m_d) begin
            m_run++;
            if (m_run == STABLE_CYCLES) begin
                m_d   = s;
                m_run = 0;
            end
        end else begin
            if (m_run > 0 && m_gl < 255) m_gl++;
            m_run = 0;
        end
        if (clr) m_gl = 0;
    endfunction

    // One clock of stimulus: drive at the falling edge, predict the next rise.
    task automatic step(input logic raw, input logic clr, input logic rstv);
        exp_t e;
        @(negedge clk);
        raw_i = raw;
        clr_i = clr;
        rst   = rstv;
        if (!rstv) model_reset();
        else       model_edge(raw, clr);
        e.d    = m_d;
        e.busy = (m_run > 0);
        e.gcnt = m_gl[7:0];
        exp_q.push_back(e);
    endtask

    task automatic hold(input logic raw, input int n);
        for (int i = 0; i < n; i++) step(raw, 1'b0, 1'b1);
    endtask

    task automatic check_now(input string name, input logic [9:0] got, input logic [9:0] want);
        n_vec++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got d=%0b busy=%0b gcnt=%0d, want d=%0b busy=%0b gcnt=%0d",
                     name, got[9], got[8], got[7:0], want[9], want[8], want[7:0]);
        end
    endtask

    // Monitor: compare every predicted vector shortly after its rising edge.
    always @(posedge clk) begin
        exp_t e;
        #2;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check_now(phase, {d_o, busy_o, glitch_cnt_o}, {e.d, e.busy, e.gcnt});
        end
    end

    initial begin
        logic lvl;
        int   len;

        model_reset();

        // Reset held with raw high, then released with raw still high.
        phase = "reset_hold";
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0);
        phase = "reset_release";
        hold(1'b1, 14);
        hold(1'b0, 14);

        // Clean rise and fall.
        phase = "clean_edges";
        hold(1'b1, 20);
        hold(1'b0, 20);

        // Short and near-qualifying glitches.
        phase = "glitch4";
        hold(1'b1, 4);
        hold(1'b0, 12);
        phase = "glitch7";
        hold(1'b1, 7);
        hold(1'b0, 12);

        // Exactly STABLE_CYCLES high: qualifies, then falls back.
        phase = "boundary8";
        hold(1'b1, 8);
        hold(1'b0, 24);

        // Saturate the glitch counter.
        phase = "saturate";
        for (int i = 0; i < 300; i++) begin
            hold(1'b1, 3);
            hold(1'b0, 3);
        end
        hold(1'b0, 4);

        // Clear asserted across a whole glitch, covering its rejection edge.
        phase = "clear_vs_glitch";
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1);
        hold(1'b0, 4);

        // Reset in the middle of a qualification window.
        phase = "reset_mid";
        hold(1'b1, 7);
        @(posedge clk);
        #3;
        check_now("busy_before_reset", {d_o, busy_o, glitch_cnt_o},
                  {m_d, (m_run > 0), m_gl[7:0]});
        rst = 1'b0;
        #1;
        check_now("async_reset_effect", {d_o, busy_o, glitch_cnt_o},
                  {RESET_VAL, 1'b0, 8'd0});
        model_reset();
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        phase = "reset_mid_release";
        hold(1'b1, 14);
        hold(1'b0, 14);

        // Randomized level runs with occasional clears and resets.
        phase = "random";
        for (int r = 0; r < 400; r++) begin
            lvl = 1'($urandom_range(0, 1));
            len = $urandom_range(1, 14);
            for (int i = 0; i < len; i++) begin
                if ($urandom_range(0, 599) == 0) step(lvl, 1'b0, 1'b0);
                else step(lvl, ($urandom_range(0, 19) == 0), 1'b1);
            end
        end
        hold(1'b0, 12);

        // Drain the scoreboard within a bounded number of cycles.
        for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(posedge clk);
        #4;
        n_vec++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending, want 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
